// File: rtl/ps2kbd_fifo_funcmod.sv
// PS/2 keyboard receiver: synchronised/filtered line sampling, frame check, E0/F0 prefix
// decoding with modifier tracking, and a show-ahead event FIFO.
module ps2kbd_fifo_funcmod #(
  parameter int unsigned FILTER_LEN   = 4,
  parameter int unsigned TIMEOUT      = 50000,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned REPORT_BREAK = 1
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   PS2_CLK,
  input  logic                   PS2_DAT,
  input  logic                   iRead,
  output logic [15:0]            oData,
  output logic                   oEmpty,
  output logic [$clog2(DEPTH):0] oCount,
  output logic                   oTrig,
  output logic [5:0]             oTag,
  output logic                   oErr,
  output logic                   oOvf
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CntOne  = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne = AW'(1);

  // ---------------- line synchronisers and clock filter ----------------
  logic [1:0] clkSyncQ, datSyncQ;
  logic       filtQ;
  logic [3:0] filtCntQ;
  logic       fallEdge, datBit;

  assign datBit   = datSyncQ[1];
  // Fires in the cycle the filtered clock commits to 0.
  assign fallEdge = filtQ & ~clkSyncQ[1] & (filtCntQ == 4'(FILTER_LEN - 1));

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      clkSyncQ <= 2'b11;
      datSyncQ <= 2'b11;
      filtQ    <= 1'b1;
      filtCntQ <= '0;
    end else begin
      clkSyncQ <= {clkSyncQ[0], PS2_CLK};
      datSyncQ <= {datSyncQ[0], PS2_DAT};
      if (clkSyncQ[1] == filtQ) begin
        filtCntQ <= '0;
      end else if (filtCntQ == 4'(FILTER_LEN - 1)) begin
        filtQ    <= clkSyncQ[1];
        filtCntQ <= '0;
      end else begin
        filtCntQ <= filtCntQ + 4'd1;
      end
    end
  end

  // ---------------- frame receiver ----------------
  logic [3:0]    bitCntQ;
  logic [7:0]    shiftQ;
  logic          parQ;
  logic [TW-1:0] toCntQ;
  logic          frameEnd, timeout, byteOk, frameErr;

  assign frameEnd = fallEdge && (bitCntQ == 4'd10);
  assign timeout  = (bitCntQ != 4'd0) && !fallEdge && (toCntQ == TW'(TIMEOUT - 1));
  assign byteOk   = frameEnd && ((^shiftQ) ^ parQ) && datBit;
  assign frameErr = (frameEnd && !byteOk) || timeout;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      bitCntQ <= '0;
      shiftQ  <= '0;
      parQ    <= 1'b0;
      toCntQ  <= '0;
    end else begin
      if (timeout) begin
        bitCntQ <= '0;
      end else if (fallEdge) begin
        if (bitCntQ == 4'd0) begin
          if (!datBit) bitCntQ <= 4'd1;
        end else if (bitCntQ <= 4'd8) begin
          shiftQ  <= {datBit, shiftQ[7:1]};
          bitCntQ <= bitCntQ + 4'd1;
        end else if (bitCntQ == 4'd9) begin
          parQ    <= datBit;
          bitCntQ <= bitCntQ + 4'd1;
        end else begin
          bitCntQ <= '0;
        end
      end
      if (fallEdge || bitCntQ == 4'd0) toCntQ <= '0;
      else                             toCntQ <= toCntQ + TW'(1);
    end
  end

  // ---------------- prefix decoder and modifier tracking ----------------
  typedef enum logic [1:0] {StIdle, StE0, StF0, StE0F0} decState_e;

  decState_e   stateQ, stateD;
  logic [5:0]  tagQ, tagD;
  logic        pushQ, pushD;
  logic [15:0] pushDataQ, pushDataD;
  logic        errQ;
  logic        isExt, isBrk, isMod;
  logic [2:0]  modIdx;

  always_comb begin
    stateD    = stateQ;
    tagD      = tagQ;
    pushD     = 1'b0;
    pushDataD = pushDataQ;
    isExt     = (stateQ == StE0) || (stateQ == StE0F0);
    isBrk     = (stateQ == StF0) || (stateQ == StE0F0);
    isMod     = 1'b1;
    modIdx    = 3'd0;
    case ({isExt, shiftQ})
      9'h012:  modIdx = 3'd2;
      9'h059:  modIdx = 3'd5;
      9'h014:  modIdx = 3'd1;
      9'h114:  modIdx = 3'd4;
      9'h011:  modIdx = 3'd0;
      9'h111:  modIdx = 3'd3;
      default: isMod  = 1'b0;
    endcase
    if (frameErr) begin
      stateD = StIdle;
    end else if (byteOk) begin
      if (shiftQ == 8'hE0) begin
        stateD = StE0;
      end else if (shiftQ == 8'hF0) begin
        if (stateQ == StIdle)    stateD = StF0;
        else if (stateQ == StE0) stateD = StE0F0;
      end else begin
        stateD = StIdle;
        if (isMod) begin
          tagD[modIdx] = ~isBrk;
        end else if (!isBrk || REPORT_BREAK != 0) begin
          pushD     = 1'b1;
          pushDataD = {isBrk, isExt, tagQ, shiftQ};
        end
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      stateQ    <= StIdle;
      tagQ      <= '0;
      pushQ     <= 1'b0;
      pushDataQ <= '0;
      errQ      <= 1'b0;
    end else begin
      stateQ    <= stateD;
      tagQ      <= tagD;
      pushQ     <= pushD;
      pushDataQ <= pushDataD;
      errQ      <= frameErr;
    end
  end

  // ---------------- event FIFO ----------------
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wrPtrQ, rdPtrQ;
  logic [AW:0]   cntQ;
  logic          trigQ, ovfQ;
  logic          full, doPop, doPush;

  assign full   = (cntQ == FullCnt);
  assign doPop  = iRead && (cntQ != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign doPush = pushQ && (!full || doPop);

  always_ff @(posedge CLOCK) begin
    if (doPush) mem[wrPtrQ] <= pushDataQ;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      cntQ   <= '0;
      trigQ  <= 1'b0;
      ovfQ   <= 1'b0;
    end else begin
      if (doPush) wrPtrQ <= wrPtrQ + PtrOne;
      if (doPop)  rdPtrQ <= rdPtrQ + PtrOne;
      if (doPush && !doPop)      cntQ <= cntQ + CntOne;
      else if (doPop && !doPush) cntQ <= cntQ - CntOne;
      trigQ <= doPush;
      if (pushQ && full && !doPop) ovfQ <= 1'b1;
    end
  end

  assign oData  = mem[rdPtrQ];
  assign oEmpty = (cntQ == '0);
  assign oCount = cntQ;
  assign oTrig  = trigQ;
  assign oTag   = tagQ;
  assign oErr   = errQ;
  assign oOvf   = ovfQ;

endmodule

// File: tb/tb_ps2kbd_fifo_funcmod.sv
// Self-checking bench: drives PS/2 frames and compares the DUT against a byte-level
// event model (prefix flags, modifier mask, expected-entry queue).
module tb_ps2kbd_fifo_funcmod;
  localparam int unsigned FL   = 4;
  localparam int unsigned TO   = 200;
  localparam int unsigned DP   = 4;
  localparam int unsigned RB   = 1;
  localparam int          HALF = 15;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        PS2_CLK = 1'b1;
  logic        PS2_DAT = 1'b1;
  logic        iRead = 1'b0;
  logic [15:0] oData;
  logic        oEmpty;
  logic [2:0]  oCount;
  logic        oTrig;
  logic [5:0]  oTag;
  logic        oErr;
  logic        oOvf;

  ps2kbd_fifo_funcmod #(
    .FILTER_LEN  (FL),
    .TIMEOUT     (TO),
    .DEPTH       (DP),
    .REPORT_BREAK(RB)
  ) dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .PS2_CLK(PS2_CLK),
    .PS2_DAT(PS2_DAT),
    .iRead  (iRead),
    .oData  (oData),
    .oEmpty (oEmpty),
    .oCount (oCount),
    .oTrig  (oTrig),
    .oTag   (oTag),
    .oErr   (oErr),
    .oOvf   (oOvf)
  );

  always #5 CLOCK = ~CLOCK;

  int nChecks = 0;
  int nPass   = 0;

  // Model state: expected FIFO contents, modifier mask, sticky overflow, pending prefixes.
  logic [15:0] mq[$];
  logic [5:0]  mTag = '0;
  logic        mOvf = 1'b0;
  logic        mExt = 1'b0;
  logic        mBrk = 1'b0;
  int          expTrig = 0, expErr = 0, seenTrig = 0, seenErr = 0;
  bit          quiet = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic modelByte(input logic [7:0] b);
    int idx;
    if (b == 8'hE0) begin
      mExt = 1'b1;
      mBrk = 1'b0;
    end else if (b == 8'hF0) begin
      mBrk = 1'b1;
    end else begin
      idx = -1;
      if (!mExt && b == 8'h12) idx = 2;
      if (!mExt && b == 8'h59) idx = 5;
      if (!mExt && b == 8'h14) idx = 1;
      if ( mExt && b == 8'h14) idx = 4;
      if (!mExt && b == 8'h11) idx = 0;
      if ( mExt && b == 8'h11) idx = 3;
      if (idx >= 0) begin
        mTag[idx] = !mBrk;
      end else if (!mBrk || RB != 0) begin
        if (mq.size() < DP) begin
          mq.push_back({mBrk, mExt, mTag, b});
          expTrig++;
        end else begin
          mOvf = 1'b1;
        end
      end
      mExt = 1'b0;
      mBrk = 1'b0;
    end
  endtask

  task automatic ps2Bit(input logic d);
    PS2_DAT = d;
    repeat (HALF) @(posedge CLOCK);
    PS2_CLK = 1'b0;
    repeat (HALF) @(posedge CLOCK);
    PS2_CLK = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic badPar);
    quiet = 1'b0;
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(b[i]);
    ps2Bit((~^b) ^ badPar);
    ps2Bit(1'b1);
    repeat (HALF) @(posedge CLOCK);
    #1;
    if (badPar) begin
      expErr++;
      mExt = 1'b0;
      mBrk = 1'b0;
    end else begin
      modelByte(b);
    end
    quiet = 1'b1;
  endtask

  task automatic doRead();
    @(posedge CLOCK);
    #1 iRead = 1'b1;
    @(posedge CLOCK);
    #1 iRead = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic popExp(input string name, input logic [15:0] exp);
    @(negedge CLOCK);
    chk(name, 32'(oData), 32'(exp));
    doRead();
  endtask

  // Pulse counters: a stuck or doubled pulse shows up as a count difference.
  always @(negedge CLOCK) begin
    if (RESET) begin
      if (oTrig === 1'b1) seenTrig++;
      if (oErr === 1'b1)  seenErr++;
    end
  end

  always @(negedge CLOCK) begin
    if (quiet) begin
      chk("count", 32'(oCount), 32'(mq.size()));
      chk("empty", 32'(oEmpty), 32'(mq.size() == 0));
      if (mq.size() != 0) chk("data", 32'(oData), 32'(mq[0]));
      chk("tag", 32'(oTag), 32'(mTag));
      chk("ovf", 32'(oOvf), 32'(mOvf));
      chk("trigCount", 32'(seenTrig), 32'(expTrig));
      chk("errCount", 32'(seenErr), 32'(expErr));
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pool [13];
    logic [7:0] b;
    pool = '{8'h12, 8'h59, 8'h14, 8'h11, 8'hE0, 8'hF0, 8'h1C, 8'h32, 8'h75, 8'h15,
             8'h2D, 8'hE0, 8'hF0};

    // Reset state
    repeat (4) @(negedge CLOCK);
    chk("rstEmpty", 32'(oEmpty), 32'd1);
    chk("rstCount", 32'(oCount), 32'd0);
    chk("rstTag", 32'(oTag), 32'd0);
    chk("rstOvf", 32'(oOvf), 32'd0);
    chk("rstTrig", 32'(oTrig), 32'd0);
    chk("rstErr", 32'(oErr), 32'd0);
    @(posedge CLOCK);
    #1 RESET = 1'b1;
    quiet = 1'b1;
    repeat (5) @(posedge CLOCK);

    // Single make code
    sendFrame(8'h1C, 1'b0);
    @(negedge CLOCK);
    chk("oneFrameData", 32'(oData), 32'h001C);
    chk("oneFrameCount", 32'(oCount), 32'd1);
    chk("oneFrameTrig", 32'(seenTrig), 32'd1);
    doRead();
    @(negedge CLOCK);
    chk("oneFrameEmpty", 32'(oEmpty), 32'd1);

    // Idle-line clock pulse with data high must be ignored
    ps2Bit(1'b1);
    repeat (HALF) @(posedge CLOCK);

    // LShift held around a key, then released
    sendFrame(8'h12, 1'b0);
    @(negedge CLOCK);
    chk("lshiftTag", 32'(oTag), 32'h04);
    sendFrame(8'h1C, 1'b0);
    sendFrame(8'hF0, 1'b0);
    sendFrame(8'h1C, 1'b0);
    sendFrame(8'hF0, 1'b0);
    sendFrame(8'h12, 1'b0);
    @(negedge CLOCK);
    chk("shiftEndTag", 32'(oTag), 32'h00);
    chk("shiftEndCount", 32'(oCount), 32'd2);
    popExp("shiftMake", 16'h041C);
    popExp("shiftBreak", 16'h841C);

    // Extended make/break and extended modifier
    sendFrame(8'hE0, 1'b0);
    sendFrame(8'h75, 1'b0);
    sendFrame(8'hE0, 1'b0);
    sendFrame(8'hF0, 1'b0);
    sendFrame(8'h75, 1'b0);
    popExp("extMake", 16'h4075);
    popExp("extBreak", 16'hC075);
    sendFrame(8'hE0, 1'b0);
    sendFrame(8'h14, 1'b0);
    @(negedge CLOCK);
    chk("rctrlTag", 32'(oTag), 32'h10);
    chk("rctrlNoPush", 32'(oCount), 32'd0);
    sendFrame(8'hE0, 1'b0);
    sendFrame(8'hF0, 1'b0);
    sendFrame(8'h14, 1'b0);

    // Parity error then a good frame
    sendFrame(8'h1C, 1'b1);
    @(negedge CLOCK);
    chk("parityErr", 32'(seenErr), 32'd1);
    chk("parityNoPush", 32'(oCount), 32'd0);
    sendFrame(8'h32, 1'b0);
    popExp("afterParity", 16'h0032);

    // Truncated frame followed by timeout
    quiet = 1'b0;
    ps2Bit(1'b0);
    for (int i = 0; i < 4; i++) ps2Bit(1'b1);
    repeat (TO + 10) @(posedge CLOCK);
    #1;
    expErr++;
    mExt = 1'b0;
    mBrk = 1'b0;
    quiet = 1'b1;
    @(negedge CLOCK);
    chk("timeoutErr", 32'(seenErr), 32'd2);
    sendFrame(8'h1C, 1'b0);
    popExp("afterTimeout", 16'h001C);

    // Overflow
    sendFrame(8'h15, 1'b0);
    sendFrame(8'h1D, 1'b0);
    sendFrame(8'h24, 1'b0);
    sendFrame(8'h2D, 1'b0);
    sendFrame(8'h2C, 1'b0);
    @(negedge CLOCK);
    chk("ovfCount", 32'(oCount), 32'd4);
    chk("ovfFlag", 32'(oOvf), 32'd1);
    popExp("ovfRd0", 16'h0015);
    popExp("ovfRd1", 16'h001D);
    popExp("ovfRd2", 16'h0024);
    popExp("ovfRd3", 16'h002D);
    @(negedge CLOCK);
    chk("ovfDrained", 32'(oEmpty), 32'd1);
    doRead();

    // Reset in the middle of a frame
    sendFrame(8'h12, 1'b0);
    sendFrame(8'h32, 1'b0);
    quiet = 1'b0;
    ps2Bit(1'b0);
    ps2Bit(1'b1);
    ps2Bit(1'b0);
    @(posedge CLOCK);
    #1 RESET = 1'b0;
    mq.delete();
    mTag = '0;
    mOvf = 1'b0;
    mExt = 1'b0;
    mBrk = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1 RESET = 1'b1;
    quiet = 1'b1;
    @(negedge CLOCK);
    chk("midRstCount", 32'(oCount), 32'd0);
    chk("midRstTag", 32'(oTag), 32'd0);
    chk("midRstOvf", 32'(oOvf), 32'd0);
    sendFrame(8'h1C, 1'b0);
    popExp("afterMidRst", 16'h001C);

    // Randomised traffic
    for (int n = 0; n < 80; n++) begin
      b = pool[$urandom_range(0, 12)];
      sendFrame(b, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 1) begin
        for (int r = 0; r < int'($urandom_range(0, 2)); r++) doRead();
      end
    end
    while (mq.size() != 0) doRead();
    doRead();
    repeat (4) @(posedge CLOCK);

    quiet = 1'b0;
    @(negedge CLOCK);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/ps2kbd_fifo_funcmod.md
PS2KBD_FIFO_FUNCMOD -- requirements
Module: ps2kbd_fifo_funcmod

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive equal synchronised PS2_CLK samples needed before the filtered clock changes (range 1..15).
REQ-002 Parameter TIMEOUT, default 50000: clocks without a filtered falling edge, mid-frame, before the frame is aborted.
REQ-003 Parameter DEPTH, default 8: event FIFO entries, a power of 2, minimum 2.
REQ-004 Parameter REPORT_BREAK, default 1: 1 = push break events for non-modifier keys; 0 = push make events only.
REQ-005 CLOCK  in  1  system clock; all logic on its rising edge.
REQ-006 RESET  in  1  asynchronous, active-low reset.
REQ-007 PS2_CLK  in  1  raw PS/2 clock from the keyboard.
REQ-008 PS2_DAT  in  1  raw PS/2 data from the keyboard.
REQ-009 iRead  in  1  pop request; honoured only while oEmpty=0.
REQ-010 oData  out  16  FIFO head {brk, ext, tag[5:0], code[7:0]}; valid while oEmpty=0 (show-ahead).
REQ-011 oEmpty  out  1  FIFO empty.
REQ-012 oCount  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-013 oTrig  out  1  one-clock pulse per accepted FIFO push.
REQ-014 oTag  out  6  live modifier state: [5]RShift, [4]RCtrl, [3]RAlt, [2]LShift, [1]LCtrl, [0]LAlt.
REQ-015 oErr  out  1  one-clock pulse per discarded frame (start, parity, stop or timeout error).
REQ-016 oOvf  out  1  sticky flag: an event was dropped because the FIFO was full.

Function
REQ-017 PS2_CLK and PS2_DAT shall each pass through a 2-flop synchroniser reset to 1; the filtered clock shall take the synchronised value only after FILTER_LEN equal consecutive samples.
REQ-018 Each filtered 1->0 transition is one edge; the synchronised PS2_DAT shall be sampled in the same clock.
REQ-019 Frame format: start(0), 8 data bits LSB first, odd parity, stop(1); bit counter 0..10.
REQ-020 Edge at bit 0 with data=1: edge ignored, counter stays 0, no oErr.
REQ-021 Frame is valid only if XOR(data[7:0], parity)=1 and stop=1; otherwise byte discarded, oErr pulses, decoder returns to IDLE.
REQ-022 Counter nonzero and TIMEOUT clocks with no edge: counter cleared, oErr pulses, decoder returns to IDLE.
REQ-023 Decoder states IDLE, E0, F0, E0F0. IDLE+0xE0->E0; IDLE+0xF0->F0; E0+0xF0->E0F0; 0xE0 in any non-IDLE state->E0; 0xF0 in F0 or E0F0 stays in that state.
REQ-024 Any other byte forms an event {ext = state in (E0,E0F0), brk = state in (F0,E0F0), code = byte}; decoder then returns to IDLE.
REQ-025 Modifier events: (ext0,12)->bit2, (ext0,59)->bit5, (ext0,14)->bit1, (ext1,14)->bit4, (ext0,11)->bit0, (ext1,11)->bit3; make sets the bit, break clears it; modifier events are never pushed.
REQ-026 A non-modifier event is pushed with tag = oTag as it stands when the event forms; break events are pushed only if REPORT_BREAK=1.
REQ-027 Latency: with the stop-bit edge in cycle N, oTag updates in N+1; the FIFO write, the oTrig pulse and the oEmpty/oCount change occur in N+2.
REQ-028 iRead=1 with oEmpty=0 pops; the next entry appears on oData in the following cycle; iRead with oEmpty=1 has no effect.
REQ-029 Push while full with no pop: event dropped, oOvf set, no oTrig, contents unchanged.
REQ-030 Push and pop in the same cycle while full: both performed, oCount stays DEPTH, no overflow.
REQ-031 Push and pop in the same cycle with 0<oCount<DEPTH: oCount unchanged; pointers wrap modulo DEPTH.

Reset
REQ-032 RESET low shall clear the synchronisers and filter (to 1), the bit counter, the timeout counter, the decoder (IDLE), FIFO pointers, oTag, oOvf, oTrig and oErr, and set oEmpty=1 and oCount=0.
REQ-033 RESET asserted mid-frame discards the partial frame; the first complete frame after release is received normally.
REQ-034 oData is don't-care while oEmpty=1.

Verification
REQ-035 Frame 0x1C -> one oTrig; oData=0x001C, oCount=1; iRead -> oEmpty=1.
REQ-036 Bytes 12,1C,F0,1C,F0,12 with REPORT_BREAK=1 -> oTag=0x04 after 12; entries 0x041C then 0x841C; oTag=0x00 at the end; oCount=2.
REQ-037 Bytes E0,75,E0,F0,75 -> entries 0x4075 then 0xC075; E0,14 -> oTag[4]=1 with no push.
REQ-038 Frame 0x1C with wrong parity -> oErr pulse, no push; following good 0x32 -> entry 0x0032.
REQ-039 Five bits of a frame, then TIMEOUT+10 idle clocks -> one oErr; subsequent frame 0x1C is accepted.
REQ-040 DEPTH=4, makes 15,1D,24,2D,2C with no reads -> oCount=4, oOvf=1; the reads return 15,1D,24,2D in order.
